multi_pwm_generator: RTL and testbench
======================================

MULTI_PWM_GENERATOR -- requirements
Module: multi_pwm_generator

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent PWM channels.
REQ-002 SHALL have parameter CNT_W, default 4: width of the period counter, period value and each duty value.
REQ-003 SHALL have parameter RESET_PERIOD, default 2**CNT_W-1: active period after reset.
REQ-004 SHALL have port clk_3125KHz, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: run/stop control.
REQ-007 SHALL have port period, input, CNT_W bits: counter top value; the PWM frame lasts period+1 cycles.
REQ-008 SHALL have port duty, input, NUM_CH*CNT_W bits: per-channel high-cycle count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port duty_load, input, 1 bit: single-cycle strobe that captures period and duty into pending registers.
REQ-010 SHALL have port busy, output, 1 bit: high while a pending load has not yet been applied.
REQ-011 SHALL have port load_ack, output, 1 bit: one-cycle pulse when pending values become active.
REQ-012 SHALL have port pwm_out, output, NUM_CH bits: PWM outputs.
REQ-013 SHALL have port clk_div, output, 1 bit: divided clock, nominally 50% duty.
REQ-014 SHALL have port cycle_start, output, 1 bit: one-cycle pulse at the first cycle of every frame.

Function
REQ-015 SHALL use a two-state FSM: IDLE (enable=0) and RUN (enable=1); IDLE->RUN on enable=1, RUN->IDLE on enable=0, each transition taking effect at the next edge.
REQ-016 In IDLE, SHALL hold cnt at 0, drive pwm_out, clk_div and cycle_start at 0, and copy any pending values to active the same cycle, raising load_ack.
REQ-017 In RUN, SHALL increment cnt by 1 each cycle, and at cnt==active_period SHALL wrap cnt to 0 (wrap cycle).
REQ-018 SHALL register pwm_out[i] = (cnt < active_duty[i]), giving one cycle of latency from cnt.
REQ-019 SHALL hold pwm_out[i] constantly low when duty=0, and constantly high when duty>active_period.
REQ-020 SHALL register clk_div = (cnt <= active_period>>1); with period=15 this gives 8 cycles high and 8 low.
REQ-021 SHALL register cycle_start high for the cycle following cnt==0 in RUN, including the first cycle after IDLE->RUN.
REQ-022 With active_period=0, SHALL hold cnt at 0, pulse cycle_start every cycle, and drive clk_div high.
REQ-023 On duty_load, SHALL capture period and duty into pending registers and set busy at the next edge.
REQ-024 A further duty_load while busy SHALL overwrite the pending registers (latest wins).
REQ-025 On a wrap cycle with busy=1, SHALL move pending to active, clear busy and pulse load_ack at the next edge; the new values SHALL govern the frame that starts after the wrap.
REQ-026 If duty_load coincides with a wrap, SHALL apply the previously pending values (if any) and hold the new capture pending until the next boundary, with busy remaining 1.
REQ-027 Active values SHALL never change mid-frame, so pwm_out is glitch-free.

Reset
REQ-028 On rst assertion, SHALL asynchronously set: FSM to IDLE; cnt=0; active_period=RESET_PERIOD; active_duty=0; pending registers cleared; busy, load_ack, pwm_out, clk_div and cycle_start all 0.
REQ-029 rst mid-frame SHALL discard any pending load with no load_ack.
REQ-030 On rst deassertion, SHALL resume on the first rising edge with enable sampled.

Configuration
REQ-031 With macro PWM_POLARITY_EN defined, SHALL add input polarity [NUM_CH-1:0], captured and applied through the same pending/active path as duty.
REQ-032 With PWM_POLARITY_EN defined, when polarity[i]=1 SHALL invert pwm_out[i], and in IDLE or reset pwm_out[i] SHALL idle at active_polarity[i].
REQ-033 With PWM_POLARITY_EN undefined, there SHALL be no polarity port, all channels SHALL be active-high, and idle SHALL be 0.

Structure
REQ-034 Package pwm_pkg SHALL hold the FSM state typedef (IDLE, RUN) and the default constants for NUM_CH and CNT_W.
REQ-035 Sub-module pwm_channel_cmp SHALL contain the per-channel active duty (and polarity) register plus the compare/output flop, instantiated NUM_CH times with a generate loop.

Verification
REQ-036 SHALL verify: CNT_W=4, period=15, duty ch0=4, enable=1 -> pwm_out[0] high 4 of every 16 cycles; clk_div 8 high/8 low (195.3125 kHz); cycle_start every 16 cycles.
REQ-037 SHALL verify: period=9, duty={0,5,10,15} -> ch0 always low, ch1 high 5/10, ch2 and ch3 always high.
REQ-038 SHALL verify: duty_load at cnt=3 changing ch0 4->12 -> old duty until the wrap, busy high meanwhile, load_ack one cycle after the wrap, new frame 12/16 high.
REQ-039 SHALL verify: two duty_loads in one frame, second coinciding with the wrap -> first applied at this boundary, second applied at the next, busy stays 1 between them.
REQ-040 SHALL verify: rst pulse at cnt=7 with a load pending -> all outputs 0 immediately, active_period=15, no load_ack, restart from cnt=0.
REQ-041 SHALL verify, with PWM_POLARITY_EN defined: polarity[1]=1, duty=4 -> pwm_out[1] low 4/16; with enable=0, pwm_out[1] idles at 1.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and default sizing for the multi-channel PWM generator.
//   pwm_state_t    : run/stop FSM state (IDLE, RUN)
//   PWM_NUM_CH_DEF : default number of PWM channels
//   PWM_CNT_W_DEF  : default width of counter, period and duty values
// -----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    localparam int PWM_NUM_CH_DEF = 4;
    localparam int PWM_CNT_W_DEF  = 4;

endpackage

// File: rtl/pwm_channel_cmp.sv
// -----------------------------------------------------------------------------
// pwm_channel_cmp
// One PWM channel: holds the active duty (and, with PWM_POLARITY_EN defined,
// the active polarity) and registers the compare result against the shared
// period counter.
// Ports:
//   clk_3125KHz : clock, rising edge
//   rst         : asynchronous active-high reset
//   vld_p0      : counter is running (FSM in RUN)
//   apply       : load pending values into the active registers this edge
//   cnt_p0      : shared period counter
//   pend_duty   : pending duty for this channel
//   pend_pol    : pending polarity (only with PWM_POLARITY_EN)
//   pwm_p1      : registered PWM output, one cycle behind cnt_p0
// Build option: PWM_POLARITY_EN adds per-channel output polarity.
// -----------------------------------------------------------------------------
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W_DEF
) (
    input  logic             clk_3125KHz,
    input  logic             rst,
    input  logic             vld_p0,
    input  logic             apply,
    input  logic [CNT_W-1:0] cnt_p0,
    input  logic [CNT_W-1:0] pend_duty,
`ifdef PWM_POLARITY_EN
    input  logic             pend_pol,
`endif
    output logic             pwm_p1
);

    logic [CNT_W-1:0] active_duty;

`ifdef PWM_POLARITY_EN
    logic active_pol;

    always_ff @(posedge clk_3125KHz or posedge rst) begin
        if (rst) begin
            active_duty <= '0;
            active_pol  <= 1'b0;
            pwm_p1      <= 1'b0;
        end else begin
            if (apply) begin
                active_duty <= pend_duty;
                active_pol  <= pend_pol;
            end
            // stage p0 -> p1: compare, then invert; idle level is the polarity
            pwm_p1 <= vld_p0 ? ((cnt_p0 < active_duty) ^ active_pol) : active_pol;
        end
    end
`else
    always_ff @(posedge clk_3125KHz or posedge rst) begin
        if (rst) begin
            active_duty <= '0;
            pwm_p1      <= 1'b0;
        end else begin
            if (apply) begin
                active_duty <= pend_duty;
            end
            // stage p0 -> p1: duty=0 never matches, duty>period always matches
            pwm_p1 <= vld_p0 && (cnt_p0 < active_duty);
        end
    end
`endif

endmodule

// File: rtl/multi_pwm_generator.sv
// -----------------------------------------------------------------------------
// multi_pwm_generator
// NUM_CH independent PWM channels sharing one period counter, with a
// frame-aligned double-buffered update of period and duty values.
// Ports:
//   clk_3125KHz : the only clock, rising edge
//   rst         : asynchronous active-high reset
//   enable      : run (1) / stop (0)
//   period      : counter top value; frame is period+1 cycles
//   duty        : per-channel high-cycle counts, channel i at [i*CNT_W +: CNT_W]
//   duty_load   : strobe capturing period/duty (and polarity) into pending regs
//   polarity    : per-channel output inversion (only with PWM_POLARITY_EN)
//   busy        : a pending load has not yet been applied
//   load_ack    : one-cycle pulse when pending values become active
//   pwm_out     : PWM outputs
//   clk_div     : divided clock, high for cnt <= period/2
//   cycle_start : one-cycle pulse at the first cycle of every frame
// Build option: PWM_POLARITY_EN adds the polarity input.
// -----------------------------------------------------------------------------
module multi_pwm_generator
    import pwm_pkg::*;
#(
    parameter int NUM_CH       = PWM_NUM_CH_DEF,
    parameter int CNT_W        = PWM_CNT_W_DEF,
    parameter int RESET_PERIOD = 2**CNT_W - 1
) (
    input  logic                    clk_3125KHz,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    duty_load,
`ifdef PWM_POLARITY_EN
    input  logic [NUM_CH-1:0]       polarity,
`endif
    output logic                    busy,
    output logic                    load_ack,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    clk_div,
    output logic                    cycle_start
);

    localparam logic [CNT_W-1:0] RESET_PERIOD_C = CNT_W'(RESET_PERIOD);

    pwm_state_t              state;
    logic [CNT_W-1:0]        cnt_p0;
    logic [CNT_W-1:0]        active_period;
    logic [CNT_W-1:0]        pend_period;
    logic [NUM_CH*CNT_W-1:0] pend_duty;
    logic                    vld_p0;
    logic                    wrap_p0;
    logic                    apply;
    logic                    clk_div_p1;
    logic                    cycle_start_p1;

    assign vld_p0  = (state == RUN);
    assign wrap_p0 = vld_p0 && (cnt_p0 == active_period);
    // Pending values only move to active at a frame boundary; while stopped
    // there is no frame in progress, so every cycle counts as a boundary.
    assign apply   = busy && (!vld_p0 || wrap_p0);

    always_ff @(posedge clk_3125KHz or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt_p0         <= '0;
            active_period  <= RESET_PERIOD_C;
            pend_period    <= '0;
            pend_duty      <= '0;
            busy           <= 1'b0;
            load_ack       <= 1'b0;
            clk_div_p1     <= 1'b0;
            cycle_start_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_p0         <= '0;
                    clk_div_p1     <= 1'b0;
                    cycle_start_p1 <= 1'b0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt_p0         <= wrap_p0 ? '0 : cnt_p0 + 1'b1;
                    // stage p0 -> p1: frame-derived outputs
                    clk_div_p1     <= (cnt_p0 <= (active_period >> 1));
                    cycle_start_p1 <= (cnt_p0 == '0);
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            load_ack <= apply;
            if (apply) begin
                active_period <= pend_period;
            end

            // A capture on the same edge as an apply stays pending for the
            // next boundary, so busy stays set (latest capture wins).
            if (duty_load) begin
                pend_period <= period;
                pend_duty   <= duty;
                busy        <= 1'b1;
            end else if (apply) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef PWM_POLARITY_EN
    logic [NUM_CH-1:0] pend_pol;

    always_ff @(posedge clk_3125KHz or posedge rst) begin
        if (rst) begin
            pend_pol <= '0;
        end else if (duty_load) begin
            pend_pol <= polarity;
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel_cmp #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_3125KHz (clk_3125KHz),
            .rst         (rst),
            .vld_p0      (vld_p0),
            .apply       (apply),
            .cnt_p0      (cnt_p0),
            .pend_duty   (pend_duty[i*CNT_W +: CNT_W]),
`ifdef PWM_POLARITY_EN
            .pend_pol    (pend_pol[i]),
`endif
            .pwm_p1      (pwm_out[i])
        );
    end

    assign clk_div     = clk_div_p1;
    assign cycle_start = cycle_start_p1;

endmodule

// File: tb/tb_multi_pwm_generator.sv
// -----------------------------------------------------------------------------
// tb_multi_pwm_generator
// Directed and randomized stimulus for multi_pwm_generator, checked against a
// frame-position reference model and against fixed per-frame high counts.
// Build option: PWM_POLARITY_EN enables the polarity scenario.
// -----------------------------------------------------------------------------
module tb_multi_pwm_generator;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int MAXP   = 2**CNT_W - 1;

    logic                    clk_3125KHz = 1'b0;
    logic                    rst = 1'b0;
    logic                    enable = 1'b0;
    logic [CNT_W-1:0]        period = '0;
    logic [NUM_CH*CNT_W-1:0] duty = '0;
    logic                    duty_load = 1'b0;
`ifdef PWM_POLARITY_EN
    logic [NUM_CH-1:0]       polarity = '0;
`endif
    logic                    busy;
    logic                    load_ack;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    clk_div;
    logic                    cycle_start;

    multi_pwm_generator #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_3125KHz (clk_3125KHz),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .duty        (duty),
        .duty_load   (duty_load),
`ifdef PWM_POLARITY_EN
        .polarity    (polarity),
`endif
        .busy        (busy),
        .load_ack    (load_ack),
        .pwm_out     (pwm_out),
        .clk_div     (clk_div),
        .cycle_start (cycle_start)
    );

    always #5 clk_3125KHz = ~clk_3125KHz;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: position within the frame plus active/pending settings
    bit  m_run;
    int  m_pos;
    int  m_aper, m_pper;
    int  m_aduty[NUM_CH];
    int  m_pduty[NUM_CH];
    bit  m_apol[NUM_CH];
    bit  m_ppol[NUM_CH];
    bit  m_busy;
    logic [NUM_CH-1:0] e_pwm;
    logic e_clk, e_cs, e_ack, e_busy;

    // observed high counts over a window
    int hi_pwm[NUM_CH];
    int hi_clk, hi_cs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_aper = MAXP;
        m_pper = 0;
        m_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_aduty[i] = 0;
            m_pduty[i] = 0;
            m_apol[i]  = 1'b0;
            m_ppol[i]  = 1'b0;
        end
        e_pwm  = '0;
        e_clk  = 1'b0;
        e_cs   = 1'b0;
        e_ack  = 1'b0;
        e_busy = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit boundary, do_apply;
        boundary = !m_run || (m_pos == m_aper);
        do_apply = m_busy && boundary;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_run) e_pwm[i] = (m_pos < m_aduty[i]) ^ m_apol[i];
            else       e_pwm[i] = m_apol[i];
        end
        e_clk = m_run && (m_pos <= m_aper / 2);
        e_cs  = m_run && (m_pos == 0);
        e_ack = do_apply;
        m_pos = m_run ? (m_pos + 1) % (m_aper + 1) : 0;
        if (do_apply) begin
            m_aper = m_pper;
            for (int i = 0; i < NUM_CH; i++) begin
                m_aduty[i] = m_pduty[i];
                m_apol[i]  = m_ppol[i];
            end
        end
        if (duty_load) begin
            m_pper = int'(period);
            for (int i = 0; i < NUM_CH; i++) m_pduty[i] = int'(duty[i*CNT_W +: CNT_W]);
`ifdef PWM_POLARITY_EN
            for (int i = 0; i < NUM_CH; i++) m_ppol[i] = polarity[i];
`endif
            m_busy = 1'b1;
        end else if (do_apply) begin
            m_busy = 1'b0;
        end
        e_busy = m_busy;
        m_run  = enable;
    endtask

    task automatic tick();
        @(posedge clk_3125KHz);
        model_edge();
        #1;
        chk("pwm_out", pwm_out, e_pwm);
        chk("clk_div", clk_div, e_clk);
        chk("cycle_start", cycle_start, e_cs);
        chk("load_ack", load_ack, e_ack);
        chk("busy", busy, e_busy);
        for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) hi_pwm[i]++;
        if (clk_div) hi_clk++;
        if (cycle_start) hi_cs++;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NUM_CH; i++) hi_pwm[i] = 0;
        hi_clk = 0;
        hi_cs  = 0;
    endtask

    task automatic load(input logic [CNT_W-1:0] p, input logic [NUM_CH*CNT_W-1:0] d);
        period    = p;
        duty      = d;
        duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
    endtask

    task automatic sync_cs();
        int k = 0;
        while (cycle_start !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("sync_cycle_start", cycle_start, 1'b1);
    endtask

    task automatic wait_apply();
        int k = 0;
        while (busy !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        chk("apply_timeout", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_counts();

        // reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk_3125KHz);
        #1;
        chk("rst_pwm_out", pwm_out, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_load_ack", load_ack, 1'b0);
        chk("rst_clk_div", clk_div, 1'b0);
        chk("rst_cycle_start", cycle_start, 1'b0);
        rst = 1'b0;

        // load while stopped is applied on the next edge
        load(4'd15, 16'h0004);
        chk("idle_load_busy", busy, 1'b1);
        tick();
        chk("idle_apply_ack", load_ack, 1'b1);
        chk("idle_apply_busy", busy, 1'b0);

        // period 15, duty 4: 4/16 high, clk_div 8/8, one cycle_start per frame
        enable = 1'b1;
        sync_cs();
        clear_counts();
        repeat (16) tick();
        chk("p15_ch0_hi", hi_pwm[0], 4);
        chk("p15_ch1_hi", hi_pwm[1], 0);
        chk("p15_clkdiv_hi", hi_clk, 8);
        chk("p15_cs_cnt", hi_cs, 1);

        // period 9, duty {15,10,5,0}
        load(4'd9, {4'd15, 4'd10, 4'd5, 4'd0});
        wait_apply();
        sync_cs();
        clear_counts();
        repeat (10) tick();
        chk("p9_ch0_hi", hi_pwm[0], 0);
        chk("p9_ch1_hi", hi_pwm[1], 5);
        chk("p9_ch2_hi", hi_pwm[2], 10);
        chk("p9_ch3_hi", hi_pwm[3], 10);
        chk("p9_clkdiv_hi", hi_clk, 5);
        chk("p9_cs_cnt", hi_cs, 1);

        // mid-frame load at cnt=3, duty 4 -> 12
        load(4'd15, 16'h0004);
        wait_apply();
        sync_cs();              // counter now at 1
        repeat (2) tick();      // counter now at 3
        clear_counts();
        load(4'd15, 16'h000C);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("midload_busy", busy, 1'b1);
        end
        chk("midload_old_duty_hi", hi_pwm[0], 1);
        tick();
        chk("midload_ack", load_ack, 1'b1);
        chk("midload_busy_clr", busy, 1'b0);
        clear_counts();
        repeat (16) tick();
        chk("midload_new_hi", hi_pwm[0], 12);

        // two loads in a frame, the second on the wrap edge
        sync_cs();              // counter now at 1
        repeat (4) tick();      // counter now at 5
        load(4'd15, 16'h0002);
        repeat (9) tick();      // counter now at 15
        load(4'd15, 16'h0009);
        chk("dbl_first_ack", load_ack, 1'b1);
        chk("dbl_busy_held", busy, 1'b1);
        clear_counts();
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("dbl_busy_between", busy, 1'b1);
        end
        tick();
        chk("dbl_second_ack", load_ack, 1'b1);
        chk("dbl_busy_clr", busy, 1'b0);
        chk("dbl_first_hi", hi_pwm[0], 2);
        clear_counts();
        repeat (16) tick();
        chk("dbl_second_hi", hi_pwm[0], 9);

        // reset at cnt=7 with a load pending
        sync_cs();              // counter now at 1
        tick();                 // counter now at 2
        load(4'd15, 16'h0007);  // counter now at 3
        repeat (4) tick();      // counter now at 7
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_pwm_out", pwm_out, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_load_ack", load_ack, 1'b0);
        chk("arst_clk_div", clk_div, 1'b0);
        chk("arst_cycle_start", cycle_start, 1'b0);
        #2 rst = 1'b0;
        tick();
        chk("arst_no_ack", load_ack, 1'b0);
        tick();
        chk("arst_restart_cs", cycle_start, 1'b1);
        clear_counts();
        repeat (16) tick();
        chk("arst_frame_cs", hi_cs, 1);
        chk("arst_frame_clkdiv", hi_clk, 8);
        chk("arst_pending_dropped", hi_pwm[0], 0);

        // period 0: counter pinned, cycle_start every cycle, clk_div high
        load(4'd0, 16'h0001);
        wait_apply();
        clear_counts();
        repeat (5) tick();
        chk("p0_cs_cnt", hi_cs, 5);
        chk("p0_clkdiv_hi", hi_clk, 5);
        chk("p0_ch0_hi", hi_pwm[0], 5);

`ifdef PWM_POLARITY_EN
        // inverted channel 1 with duty 4: low 4 of 16, idles high when stopped
        polarity = 4'b0010;
        load(4'd15, 16'h0040);
        wait_apply();
        sync_cs();
        clear_counts();
        repeat (16) tick();
        chk("pol_ch1_hi", hi_pwm[1], 12);
        enable = 1'b0;
        repeat (2) tick();
        chk("pol_ch1_idle", pwm_out[1], 1'b1);
        enable = 1'b1;
`endif

        // randomized run/stop and load traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) begin
                period    = CNT_W'($urandom_range(0, MAXP));
                duty      = (NUM_CH*CNT_W)'($urandom);
`ifdef PWM_POLARITY_EN
                polarity  = NUM_CH'($urandom);
`endif
                duty_load = 1'b1;
            end
            tick();
            duty_load = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
